aes_inv_round_ctrl: RTL

Iterative AES decryption controller. It holds the 128-bit cipher state, fetches one round key per cycle from the expanded-key store, and applies one inverse round per clock. The round order is: first inverse round, then NR-1 middle rounds, then the final AddRoundKey. It sits between the block-level cipher interface and the combinational inverse-round datapaths, and owns the start/busy/done handshake.

---
 rtl/aes_pkg.sv | 104 ++++++++++
 rtl/inverse_first_round.sv | 23 ++
 rtl/inverse_mid_round.sv | 27 ++
 rtl/aes_inv_round_ctrl.sv | 121 ++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared types, constants and inverse-round helper functions
//
// Purpose: FSM state type, AES round-count constants, block and key-address
// widths, plus the byte-level inverse transforms used by the round datapaths.
// Byte 0 of a block is bits [127:120]; byte index i = 4*column + row.
package aes_pkg;

    localparam int NR_128   = 10;
    localparam int NR_192   = 12;
    localparam int NR_256   = 14;
    localparam int BLOCK_W  = 128;
    localparam int KA_W_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FIRST = 2'd1,
        ST_MID   = 2'd2,
        ST_LAST  = 2'd3
    } inv_fsm_e;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] t;
        p = 8'h00;
        t = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ t;
            t = xtime(t);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254 via a fixed square/multiply chain;
    // a = 0 maps to 0, which is what the S-box needs.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252;
        x2   = gf_mul(a, a);
        x3   = gf_mul(x2, a);
        x6   = gf_mul(x3, x3);
        x12  = gf_mul(x6, x6);
        x15  = gf_mul(x12, x3);
        x30  = gf_mul(x15, x15);
        x60  = gf_mul(x30, x30);
        x120 = gf_mul(x60, x60);
        x240 = gf_mul(x120, x120);
        x252 = gf_mul(x240, x12);
        return gf_mul(x252, x2);
    endfunction

    // Inverse S-box: undo the affine map (rotations by 1, 3, 6 and 0x05), then invert.
    function automatic logic [7:0] inv_sbox(input logic [7:0] x);
        logic [7:0] b;
        b = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
        return gf_inv(b);
    endfunction

    function automatic logic [BLOCK_W-1:0] round_xor(input logic [BLOCK_W-1:0] s,
                                                     input logic [BLOCK_W-1:0] k);
        return s ^ k;
    endfunction

    function automatic logic [BLOCK_W-1:0] inv_sub_bytes(input logic [BLOCK_W-1:0] s);
        logic [BLOCK_W-1:0] o;
        o = '0;
        for (int i = 0; i < 16; i++) begin
            o[127-8*i -: 8] = inv_sbox(s[127-8*i -: 8]);
        end
        return o;
    endfunction

    // Row r is rotated right by r columns: out[r,c] = in[r,(c-r) mod 4].
    function automatic logic [BLOCK_W-1:0] inv_shift_rows(input logic [BLOCK_W-1:0] s);
        logic [BLOCK_W-1:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+4-r)%4)+r) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [BLOCK_W-1:0] inv_mix_columns(input logic [BLOCK_W-1:0] s);
        logic [BLOCK_W-1:0] o;
        logic [7:0] a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-8*(4*c)   -: 8];
            a1 = s[127-8*(4*c+1) -: 8];
            a2 = s[127-8*(4*c+2) -: 8];
            a3 = s[127-8*(4*c+3) -: 8];
            o[127-8*(4*c)   -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
            o[127-8*(4*c+1) -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
            o[127-8*(4*c+2) -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
            o[127-8*(4*c+3) -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
        end
        return o;
    endfunction

endpackage

// File: rtl/inverse_first_round.sv
// rtl/inverse_first_round.sv - combinational first inverse round
//
// Purpose: o_state = InvSubBytes(InvShiftRows(i_state ^ i_key)).
// Ports:
//   i_state  128  current cipher state
//   i_key    128  round key NR
//   o_state  128  state after the first inverse round
module inverse_first_round
    import aes_pkg::*;
(
    input  logic [BLOCK_W-1:0] i_state,
    input  logic [BLOCK_W-1:0] i_key,
    output logic [BLOCK_W-1:0] o_state
);

    logic [BLOCK_W-1:0] w_xor;
    logic [BLOCK_W-1:0] w_shift;

    assign w_xor   = round_xor(i_state, i_key);
    assign w_shift = inv_shift_rows(w_xor);
    assign o_state = inv_sub_bytes(w_shift);

endmodule

// File: rtl/inverse_mid_round.sv
// rtl/inverse_mid_round.sv - combinational middle inverse round
//
// Purpose: o_state = InvSubBytes(InvShiftRows(InvMixColumns(i_state ^ i_key))).
// AddRoundKey is applied before InvMixColumns, so the stored round keys are
// the plain expanded keys (no InvMixColumns pre-transform needed).
// Ports:
//   i_state  128  current cipher state
//   i_key    128  round key for this round
//   o_state  128  state after the round
module inverse_mid_round
    import aes_pkg::*;
(
    input  logic [BLOCK_W-1:0] i_state,
    input  logic [BLOCK_W-1:0] i_key,
    output logic [BLOCK_W-1:0] o_state
);

    logic [BLOCK_W-1:0] w_xor;
    logic [BLOCK_W-1:0] w_mix;
    logic [BLOCK_W-1:0] w_shift;

    assign w_xor   = round_xor(i_state, i_key);
    assign w_mix   = inv_mix_columns(w_xor);
    assign w_shift = inv_shift_rows(w_mix);
    assign o_state = inv_sub_bytes(w_shift);

endmodule

// File: rtl/aes_inv_round_ctrl.sv
// rtl/aes_inv_round_ctrl.sv - iterative AES decryption round controller
//
// Purpose: holds the cipher state and applies one inverse round per clock,
// reading round keys NR down to 0 from an external same-cycle key store.
// Ports:
//   clk        in   1     system clock, rising edge
//   rst        in   1     asynchronous active-high reset
//   start      in   1     decrypt request, sampled only in IDLE
//   cipher_in  in   128   ciphertext, captured on the accepted start edge
//   key_addr   out  KA_W  round-key index for this cycle
//   key_rd     out  1     key_data consumed this cycle
//   key_data   in   128   round key at key_addr (combinational read)
//   busy       out  1     decryption in progress
//   done       out  1     one-cycle pulse, plain_out valid
//   plain_out  out  128   plaintext, held until the next result
module aes_inv_round_ctrl
    import aes_pkg::*;
#(
    parameter int NR   = NR_128,
    parameter int KA_W = KA_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [BLOCK_W-1:0] cipher_in,
    output logic [KA_W-1:0]    key_addr,
    output logic               key_rd,
    input  logic [BLOCK_W-1:0] key_data,
    output logic               busy,
    output logic               done,
    output logic [BLOCK_W-1:0] plain_out
);

    inv_fsm_e           r_fsm;
    logic [KA_W-1:0]    r_round;
    logic [BLOCK_W-1:0] r_state;
    logic [BLOCK_W-1:0] r_plain;
    logic [KA_W-1:0]    r_key_addr;
    logic               r_key_rd;
    logic               r_busy;
    logic               r_done;

    logic [BLOCK_W-1:0] w_first_state;
    logic [BLOCK_W-1:0] w_mid_state;
    logic [BLOCK_W-1:0] w_last_state;

    inverse_first_round u_first (
        .i_state (r_state),
        .i_key   (key_data),
        .o_state (w_first_state)
    );

    inverse_mid_round u_mid (
        .i_state (r_state),
        .i_key   (key_data),
        .o_state (w_mid_state)
    );

    assign w_last_state = round_xor(r_state, key_data);

    // key_addr/key_rd/busy are registered one transition ahead, so they are
    // already valid in the cycle the corresponding state is active.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fsm      <= ST_IDLE;
            r_round    <= '0;
            r_state    <= '0;
            r_plain    <= '0;
            r_key_addr <= '0;
            r_key_rd   <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_fsm)
                ST_IDLE: begin
                    if (start) begin
                        r_state    <= cipher_in;
                        r_round    <= KA_W'(NR);
                        r_key_addr <= KA_W'(NR);
                        r_key_rd   <= 1'b1;
                        r_busy     <= 1'b1;
                        r_fsm      <= ST_FIRST;
                    end
                end
                ST_FIRST: begin
                    r_state    <= w_first_state;
                    r_round    <= KA_W'(NR - 1);
                    r_key_addr <= KA_W'(NR - 1);
                    r_fsm      <= ST_MID;
                end
                ST_MID: begin
                    r_state    <= w_mid_state;
                    r_round    <= r_round - KA_W'(1);
                    r_key_addr <= r_round - KA_W'(1);
                    if (r_round == KA_W'(1)) begin
                        r_fsm <= ST_LAST;
                    end
                end
                ST_LAST: begin
                    r_plain    <= w_last_state;
                    r_done     <= 1'b1;
                    r_busy     <= 1'b0;
                    r_key_rd   <= 1'b0;
                    r_key_addr <= '0;
                    r_fsm      <= ST_IDLE;
                end
                default: begin
                    r_fsm <= ST_IDLE;
                end
            endcase
        end
    end

    assign key_addr  = r_key_addr;
    assign key_rd    = r_key_rd;
    assign busy      = r_busy;
    assign done      = r_done;
    assign plain_out = r_plain;

endmodule
